// File: rtl/spc7110_dport.sv
// SPC7110 data-ROM read port: pointer/offset/step/mode registers, one-byte prefetch buffer and
// fetch FSM. Define SPC7110_DPORT_SIGNED_EN to implement mode[3] (sign-extended step/ofs).
module spc7110_dport #(
  parameter logic [23:0] DROM_BASE = 24'h100000,
  parameter logic [23:0] DROM_MASK = 24'h7FFFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        reg_we_i,
  input  logic        reg_rd_i,
  input  logic [3:0]  reg_addr_i,
  input  logic [7:0]  reg_wdata_i,
  output logic [7:0]  reg_rdata_o,
  output logic        rom_req_o,
  output logic [23:0] rom_addr_o,
  input  logic        rom_ack_i,
  input  logic [7:0]  rom_data_i,
  output logic        busy_o
);

  typedef enum logic {StIdle, StReq} state_e;

`ifdef SPC7110_DPORT_SIGNED_EN
  localparam logic [7:0] ModeWrMask = 8'hFF;
`else
  localparam logic [7:0] ModeWrMask = 8'hF7;
`endif

  state_e      state_q;
  logic [23:0] ptr_q, ptr_d;
  logic [15:0] ofs_q, ofs_d;
  logic [15:0] step_q, step_d;
  logic [7:0]  mode_q, mode_d;
  logic [7:0]  dbuf_q;
  logic        dirty_q;
  logic        rom_req_q;
  logic [23:0] rom_addr_q;
  logic        dirty_evt;
  logic        signed_mode;
  logic [23:0] fetch_addr;

  // mode[3] is forced to zero on write when the signed feature is absent.
  assign signed_mode = mode_q[3];

  function automatic logic [23:0] ext16(input logic [15:0] v, input logic sgn);
    return sgn ? {{8{v[15]}}, v} : {8'h00, v};
  endfunction

  always_comb begin
    ptr_d     = ptr_q;
    ofs_d     = ofs_q;
    step_d    = step_q;
    mode_d    = mode_q;
    dirty_evt = 1'b0;
    if (reg_we_i) begin
      // A simultaneous read strobe loses its pointer advance.
      case (reg_addr_i)
        4'h1: begin ptr_d[7:0]   = reg_wdata_i; dirty_evt = 1'b1; end
        4'h2: begin ptr_d[15:8]  = reg_wdata_i; dirty_evt = 1'b1; end
        4'h3: begin ptr_d[23:16] = reg_wdata_i; dirty_evt = 1'b1; end
        4'h4: begin ofs_d[7:0]   = reg_wdata_i; dirty_evt = 1'b1; end
        4'h5: begin
          ofs_d[15:8] = reg_wdata_i;
          dirty_evt   = 1'b1;
          if (mode_q[6:5] == 2'b01) begin
            ptr_d = ptr_q + ext16({reg_wdata_i, ofs_q[7:0]}, signed_mode);
          end
        end
        4'h6: begin step_d[7:0]  = reg_wdata_i; dirty_evt = 1'b1; end
        4'h7: begin step_d[15:8] = reg_wdata_i; dirty_evt = 1'b1; end
        4'h8: begin mode_d = reg_wdata_i & ModeWrMask; dirty_evt = 1'b1; end
        default: ;
      endcase
    end else if (reg_rd_i) begin
      if (reg_addr_i == 4'h0) begin
        ptr_d     = ptr_q + (mode_q[0] ? ext16(step_q, signed_mode) : 24'd1);
        dirty_evt = 1'b1;
      end else if (reg_addr_i == 4'hA && mode_q[6:5] == 2'b10) begin
        ptr_d     = ptr_q + ext16(ofs_q, signed_mode);
        dirty_evt = 1'b1;
      end
    end
  end

  assign fetch_addr = ((ptr_q + (mode_q[1] ? ext16(ofs_q, signed_mode) : 24'd0)) + DROM_BASE)
                      & DROM_MASK;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q  <= '0;
      ofs_q  <= '0;
      step_q <= '0;
      mode_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      ofs_q  <= ofs_d;
      step_q <= step_d;
      mode_q <= mode_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      dirty_q    <= 1'b0;
      rom_req_q  <= 1'b0;
      rom_addr_q <= '0;
      dbuf_q     <= '0;
    end else begin
      // A new event wins over the clear so a write during latch still refetches.
      dirty_q <= dirty_evt | (dirty_q & (state_q != StIdle));
      case (state_q)
        StIdle: begin
          if (dirty_q) begin
            rom_addr_q <= fetch_addr;
            rom_req_q  <= 1'b1;
            state_q    <= StReq;
          end
        end
        StReq: begin
          if (rom_ack_i) begin
            dbuf_q    <= rom_data_i;
            rom_req_q <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    reg_rdata_o = 8'h00;
    case (reg_addr_i)
      4'h0, 4'hA: reg_rdata_o = dbuf_q;
      4'h1:       reg_rdata_o = ptr_q[7:0];
      4'h2:       reg_rdata_o = ptr_q[15:8];
      4'h3:       reg_rdata_o = ptr_q[23:16];
      4'h4:       reg_rdata_o = ofs_q[7:0];
      4'h5:       reg_rdata_o = ofs_q[15:8];
      4'h6:       reg_rdata_o = step_q[7:0];
      4'h7:       reg_rdata_o = step_q[15:8];
      4'h8:       reg_rdata_o = mode_q;
      default:    reg_rdata_o = 8'h00;
    endcase
  end

  assign rom_req_o  = rom_req_q;
  assign rom_addr_o = rom_addr_q;
  assign busy_o     = dirty_q | (state_q != StIdle);

endmodule

// File: tb/tb_spc7110_dport.sv
// Directed bench for spc7110_dport: register file, pointer advance, fetch FSM and reset.
module tb_spc7110_dport;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_we = 1'b0;
  logic        reg_rd = 1'b0;
  logic [3:0]  reg_addr = 4'h0;
  logic [7:0]  reg_wdata = 8'h00;
  logic [7:0]  reg_rdata;
  logic        rom_req;
  logic [23:0] rom_addr;
  logic        rom_ack = 1'b0;
  logic [7:0]  rom_data = 8'h00;
  logic        busy;

  int errors = 0;
  int checks = 0;

  spc7110_dport dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .reg_we_i    (reg_we),
    .reg_rd_i    (reg_rd),
    .reg_addr_i  (reg_addr),
    .reg_wdata_i (reg_wdata),
    .reg_rdata_o (reg_rdata),
    .rom_req_o   (rom_req),
    .rom_addr_o  (rom_addr),
    .rom_ack_i   (rom_ack),
    .rom_data_i  (rom_data),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    reg_rd = 1'b1; reg_addr = a;
    tick();
    reg_rd = 1'b0;
  endtask

  task automatic peek(input logic [3:0] a, output logic [7:0] v);
    reg_addr = a;
    #1;
    v = reg_rdata;
  endtask

  task automatic get_ptr(output logic [23:0] p);
    logic [7:0] b0, b1, b2;
    peek(4'h1, b0); peek(4'h2, b1); peek(4'h3, b2);
    p = {b2, b1, b0};
  endtask

  // Answers every request immediately with d until the port goes idle.
  task automatic drain(input logic [7:0] d, output logic [23:0] last, output bit ok);
    ok = 1'b0; last = '0;
    for (int i = 0; i < 200; i++) begin
      if (rom_req) begin
        last = rom_addr; rom_data = d; rom_ack = 1'b1;
        tick();
        rom_ack = 1'b0;
      end else if (!busy) begin
        ok = 1'b1;
        break;
      end else begin
        tick();
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b1;
    tick(); tick();
    checks++; if (rom_req !== 1'b0 || busy !== 1'b0 || rom_addr !== 24'h0) begin
      errors++; $display("FAIL reset_outputs: req=%b busy=%b addr=%h want 0 0 000000",
                         rom_req, busy, rom_addr);
    end
    rst = 1'b0;
    for (int a = 0; a < 16; a++) begin
      peek(a[3:0], v);
      checks++; if (v !== 8'h00) begin
        errors++; $display("FAIL reset_reg%0h: got %h want 00", a, v);
      end
    end
  endtask

  task automatic test_basic_fetch();
    logic [23:0] last; bit ok; logic [7:0] v;
    wr(4'h1, 8'h00); wr(4'h2, 8'h20); wr(4'h3, 8'h00);
    drain(8'hA5, last, ok);
    checks++; if (ok !== 1'b1 || last !== 24'h102000) begin
      errors++; $display("FAIL basic_addr: ok=%b addr=%h want 1 102000", ok, last);
    end
    peek(4'h0, v);
    checks++; if (v !== 8'hA5) begin errors++; $display("FAIL basic_4810: got %h want A5", v); end
    peek(4'hA, v);
    checks++; if (v !== 8'hA5) begin errors++; $display("FAIL basic_481A: got %h want A5", v); end
    peek(4'h9, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL unmapped_4819: got %h want 00", v); end
  endtask

  task automatic test_step();
    logic [23:0] last, p; bit ok;
    wr(4'h8, 8'h01); wr(4'h6, 8'h10); wr(4'h7, 8'h00);
    wr(4'h1, 8'h00); wr(4'h2, 8'h01); wr(4'h3, 8'h00);
    drain(8'h11, last, ok);
    rd(4'h0); rd(4'h0); rd(4'h0);
    drain(8'h12, last, ok);
    get_ptr(p);
    checks++; if (p !== 24'h000130) begin errors++; $display("FAIL step_ptr: got %h want 000130", p); end
    checks++; if (ok !== 1'b1 || last !== 24'h100130) begin
      errors++; $display("FAIL step_addr: ok=%b addr=%h want 1 100130", ok, last);
    end
  endtask

  task automatic test_offset_wrap();
    logic [23:0] last; bit ok;
    wr(4'h8, 8'h02); wr(4'h4, 8'h05); wr(4'h5, 8'h00);
    wr(4'h1, 8'hFE); wr(4'h2, 8'hFF); wr(4'h3, 8'hFF);
    drain(8'h13, last, ok);
    checks++; if (ok !== 1'b1 || last !== 24'h100003) begin
      errors++; $display("FAIL ofs_wrap_addr: ok=%b addr=%h want 1 100003", ok, last);
    end
  endtask

  task automatic test_signed();
    logic [23:0] last, p, exp_p; bit ok; logic [7:0] v, exp_m;
`ifdef SPC7110_DPORT_SIGNED_EN
    exp_p = 24'h00000F; exp_m = 8'h09;
`else
    exp_p = 24'h01000F; exp_m = 8'h01;
`endif
    wr(4'h8, 8'h09); wr(4'h6, 8'hFF); wr(4'h7, 8'hFF);
    wr(4'h1, 8'h10); wr(4'h2, 8'h00); wr(4'h3, 8'h00);
    drain(8'h14, last, ok);
    rd(4'h0);
    drain(8'h15, last, ok);
    get_ptr(p);
    checks++; if (p !== exp_p) begin errors++; $display("FAIL signed_ptr: got %h want %h", p, exp_p); end
    checks++; if (last !== ((exp_p + 24'h100000) & 24'h7FFFFF)) begin
      errors++; $display("FAIL signed_addr: got %h want %h", last, (exp_p + 24'h100000) & 24'h7FFFFF);
    end
    peek(4'h8, v);
    checks++; if (v !== exp_m) begin errors++; $display("FAIL mode_readback: got %h want %h", v, exp_m); end
  endtask

  task automatic test_ofs_modes();
    logic [23:0] last, p; bit ok; logic [7:0] v;
    wr(4'h8, 8'h40); wr(4'h4, 8'h03); wr(4'h5, 8'h00);
    wr(4'h1, 8'h00); wr(4'h2, 8'h00); wr(4'h3, 8'h00);
    drain(8'h3C, last, ok);
    peek(4'hA, v);
    checks++; if (v !== 8'h3C) begin errors++; $display("FAIL 481A_data: got %h want 3C", v); end
    rd(4'hA);
    get_ptr(p);
    checks++; if (p !== 24'h000003) begin errors++; $display("FAIL 481A_adv: got %h want 000003", p); end
    wr(4'h8, 8'h20); wr(4'h4, 8'h02); wr(4'h5, 8'h01);
    get_ptr(p);
    checks++; if (p !== 24'h000105) begin errors++; $display("FAIL 4815_adv: got %h want 000105", p); end
    wr(4'h8, 8'h00);
    drain(8'h3D, last, ok);
    reg_we = 1'b1; reg_rd = 1'b1; reg_addr = 4'h0; reg_wdata = 8'hFF;
    tick();
    reg_we = 1'b0; reg_rd = 1'b0;
    get_ptr(p);
    checks++; if (p !== 24'h000105) begin errors++; $display("FAIL we_rd_same: got %h want 000105", p); end
    drain(8'h3E, last, ok);
  endtask

  task automatic test_back_to_back();
    logic [7:0] v; bit seen_idle;
    wr(4'h1, 8'h00); wr(4'h2, 8'h00); wr(4'h3, 8'h01);
    for (int i = 0; i < 20 && busy; i++) begin
      if (rom_req) begin rom_ack = 1'b1; rom_data = 8'h00; tick(); rom_ack = 1'b0; end
      else tick();
    end
    wr(4'h3, 8'h01);
    checks++; if (rom_req !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL dirty_n1: req=%b busy=%b want 0 1", rom_req, busy);
    end
    tick();
    checks++; if (rom_req !== 1'b1 || rom_addr !== 24'h110000) begin
      errors++; $display("FAIL first_req: req=%b addr=%h want 1 110000", rom_req, rom_addr);
    end
    wr(4'h3, 8'h02);
    seen_idle = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!busy || !rom_req || rom_addr !== 24'h110000) seen_idle = 1'b1;
      tick();
    end
    rom_ack = 1'b1; rom_data = 8'h11;
    tick();
    rom_ack = 1'b0;
    checks++; if (seen_idle !== 1'b0) begin
      errors++; $display("FAIL req_held: dropped=%b want 0", seen_idle);
    end
    checks++; if (rom_req !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL after_ack: req=%b busy=%b want 0 1", rom_req, busy);
    end
    peek(4'h0, v);
    checks++; if (v !== 8'h11) begin errors++; $display("FAIL first_dbuf: got %h want 11", v); end
    tick();
    checks++; if (rom_req !== 1'b1 || rom_addr !== 24'h120000 || busy !== 1'b1) begin
      errors++; $display("FAIL refetch: req=%b addr=%h busy=%b want 1 120000 1",
                         rom_req, rom_addr, busy);
    end
    rom_ack = 1'b1; rom_data = 8'h22;
    tick();
    rom_ack = 1'b0;
    peek(4'h0, v);
    checks++; if (v !== 8'h22 || busy !== 1'b0) begin
      errors++; $display("FAIL second_dbuf: got %h busy=%b want 22 0", v, busy);
    end
  endtask

  task automatic test_reset_mid_fetch();
    logic [7:0] v; logic [23:0] p; int reqs;
    wr(4'h1, 8'h55);
    tick();
    checks++; if (rom_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %b want 1", rom_req); end
    rst = 1'b1;
    tick();
    checks++; if (rom_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid: req=%b busy=%b want 0 0", rom_req, busy);
    end
    rst = 1'b0; rom_ack = 1'b1; rom_data = 8'h77;
    tick();
    rom_ack = 1'b0;
    peek(4'h0, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL late_ack_dbuf: got %h want 00", v); end
    get_ptr(p);
    checks++; if (p !== 24'h0) begin errors++; $display("FAIL rst_ptr: got %h want 000000", p); end
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      if (rom_req || busy) reqs++;
      tick();
    end
    checks++; if (reqs !== 0) begin errors++; $display("FAIL rst_no_req: got %0d want 0", reqs); end
  endtask

  task automatic test_mode_mask();
    logic [7:0] v, exp_m; logic [23:0] last; bit ok;
`ifdef SPC7110_DPORT_SIGNED_EN
    exp_m = 8'hFF;
`else
    exp_m = 8'hF7;
`endif
    wr(4'h8, 8'hFF);
    peek(4'h8, v);
    checks++; if (v !== exp_m) begin errors++; $display("FAIL mode_mask: got %h want %h", v, exp_m); end
    wr(4'h8, 8'h00);
    drain(8'h00, last, ok);
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_step();
    test_offset_wrap();
    test_signed();
    test_ofs_modes();
    test_mode_mask();
    test_back_to_back();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spc7110_dport.md
# spc7110_dport

SPC7110 data-ROM read port. Holds the $4811-$4818 pointer/offset/step/mode registers, serves $4810/$481A reads from a one-byte prefetch buffer, and advances the pointer on every data read. Sits downstream of the address decoder, whose $48xx I/O decode and chip-selects gate the strobes into this block. Issues its own byte fetches to the SDRAM/ROM arbiter.

## Interface
Parameters:
- DROM_BASE, 24'h100000, physical ROM offset of data ROM.
- DROM_MASK, 24'h7FFFFF, mask applied to the fetch address after the base is added.

Ports:
- CLK  in  1  system clock; one clock, all logic on rising edge.
- RST  in  1  reset; synchronous, active-high.
- reg_we  in  1  one-cycle write strobe, decoded $4810-$481F.
- reg_rd  in  1  one-cycle read-complete strobe, decoded $4810-$481F.
- reg_addr  in  4  SNES_ADDR[3:0] within $481x.
- reg_wdata  in  8  write data.
- reg_rdata  out  8  read data, combinational on reg_addr.
- rom_req  out  1  fetch request, registered.
- rom_addr  out  24  fetch address, stable while rom_req is high.
- rom_ack  in  1  one-cycle pulse; rom_data valid in the same cycle.
- rom_data  in  8  fetched byte.
- busy  out  1  high while a fetch is pending or in flight.

## Operation
- Registers: ptr[23:0] at $4811/12/13 (L/M/H), ofs[15:0] at $4814/15, step[15:0] at $4816/17, mode[7:0] at $4818. All read back at their own addresses.
- $4810 and $481A read the prefetch byte dbuf. Unmapped addresses read 8'h00.
- Fetch address: ptr + (mode[1] ? ext(ofs) : 0), then + DROM_BASE, then & DROM_MASK. ext() zero-extends the value to 24 bits, or sign-extends it when mode[3] is set (see Configuration).
- On a $4810 read, ptr += mode[0] ? ext(step) : 1.
- On a $481A read with mode[6:5]==2'b10, ptr += ext(ofs).
- On a $4815 write with mode[6:5]==2'b01, ptr += ext(new ofs).
- All pointer arithmetic is modulo 2^24.
- Any ptr, ofs, step or mode write, and any pointer advance, sets the dirty flag.
- FSM:
  - IDLE: if dirty, latch rom_addr, clear dirty, go to REQ.
  - REQ: drive rom_req=1; on rom_ack, load dbuf from rom_data, drop rom_req, go to IDLE.
  - A dirty event during REQ does not abort the fetch. The current fetch completes, and dirty causes a refetch from IDLE on the next cycle.
- busy = dirty | (state != IDLE). A $4810 read while busy returns the stale dbuf. The pointer still advances.
- Write and read strobes in the same cycle: the write is applied and the read's pointer advance is dropped.
- Reset values: ptr=0, ofs=0, step=0, mode=0, dbuf=0, dirty=0, state=IDLE, rom_req=0, rom_addr=0, busy=0.
- RST asserted mid-fetch returns the FSM to IDLE with rom_req=0 on the next edge. A late rom_ack is ignored.

## Timing
- A dirty event in cycle N produces rom_req high from cycle N+2: N+1 sees dirty in IDLE, N+2 is REQ.
- rom_ack sampled in cycle M:
  - dbuf updated and rom_req low from M+1.
  - busy low from M+1 unless a new dirty event occurred.
- Best case, with rom_ack in the first REQ cycle: dirty event to valid dbuf is 3 cycles.
- reg_rdata has zero latency (combinational from reg_addr and registers).

## Configuration
- SPC7110_DPORT_SIGNED_EN defined:
  - mode[3] is implemented.
  - When mode[3]=1, step and ofs are sign-extended from bit 15 for all pointer and fetch-address arithmetic.
- Not defined:
  - step and ofs are always zero-extended.
  - mode[3] is not stored and reads back 0.

## Test plan
- Reset, then write $4811=00,$4812=20,$4813=00, then wait for busy low: one fetch with rom_addr=24'h102000; respond rom_data=8'hA5 -> $4810 reads A5.
- mode=01, step=0010, ptr=000100; three $4810 reads -> ptr=000130, and the final fetch address is 24'h100130.
- mode=02, ofs=0005, ptr=FFFFFE -> fetch address (FFFFFE+5+100000)&7FFFFF = 24'h100003.
- SIGNED_EN build, mode=09, step=FFFF, ptr=000010, one $4810 read -> ptr=00000F. Non-SIGNED build with the same stimulus -> ptr=01000F.
- Write $4813 during REQ with rom_ack delayed 5 cycles: the first fetch completes, then a second rom_req follows with the new address; busy stays high throughout.
- Assert RST while rom_req=1, then pulse rom_ack: rom_req=0 and dbuf=00 after reset; no further request.
